// File: rtl/alu_regfile_if.sv
// alu_regfile_if: register-file read/write port and ALU result bundle.
// The master side (environment) drives addresses, write port and opcode.
// The slave side (alu_regfile) returns read data, ALU result and flags.
interface alu_regfile_if #(
  parameter int DATA_WIDTH = 16,
  parameter int NUM_REGS   = 8
);
  localparam int AW = $clog2(NUM_REGS);

  logic [AW-1:0]         address_a;
  logic [AW-1:0]         address_b;
  logic [AW-1:0]         write_address;
  logic                  write_enable;
  logic [DATA_WIDTH-1:0] write_data;
  logic [3:0]            opcode;
  logic [DATA_WIDTH-1:0] data_a;
  logic [DATA_WIDTH-1:0] data_b;
  logic [DATA_WIDTH-1:0] alu_result;
  logic                  zero;
  logic                  carry;

  modport master (
    output address_a, address_b, write_address, write_enable, write_data, opcode,
    input  data_a, data_b, alu_result, zero, carry
  );

  modport slave (
    input  address_a, address_b, write_address, write_enable, write_data, opcode,
    output data_a, data_b, alu_result, zero, carry
  );
endinterface

// File: rtl/alu_regfile.sv
// alu_regfile: NUM_REGS x DATA_WIDTH register file with two combinational
// read ports, one synchronous write port and a combinational ALU on the
// two read values.
// Optional feature: define ALU_REGFILE_BYPASS_EN to forward write_data to a
// read port whose address matches the write address in the same cycle.
//
// Write port semantics: there is no ready; a write is accepted at every
// rising clk edge where write_enable is high and the block is out of reset.
module alu_regfile #(
  parameter int DATA_WIDTH = 16,
  parameter int NUM_REGS   = 8
) (
  input  logic          clk,
  input  logic          rst,
  alu_regfile_if.slave  bus
);
  localparam int AW = $clog2(NUM_REGS);

  localparam logic [3:0] OP_ADD = 4'b0010;
  localparam logic [3:0] OP_SUB = 4'b0011;
  localparam logic [3:0] OP_AND = 4'b0100;
  localparam logic [3:0] OP_OR  = 4'b0101;
  localparam logic [3:0] OP_XOR = 4'b0110;
  localparam logic [3:0] OP_NOT = 4'b0111;
  localparam logic [3:0] OP_SHL = 4'b1001;
  localparam logic [3:0] OP_SHR = 4'b1010;

  logic [DATA_WIDTH-1:0] regs_q [NUM_REGS];
  logic [DATA_WIDTH-1:0] regs_d [NUM_REGS];
  logic                  rst_sync_q;
  logic                  wr_en;
  logic [DATA_WIDTH-1:0] a;
  logic [DATA_WIDTH-1:0] b;
  logic [DATA_WIDTH:0]   sum;
  logic [DATA_WIDTH-1:0] result;
  logic                  carry_flag;

  // Reset is applied asynchronously but released on a clock edge, so the
  // partial cycle in which rst drops never takes a write.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) rst_sync_q <= 1'b1;
    else     rst_sync_q <= 1'b0;
  end

  assign wr_en = bus.write_enable & ~rst_sync_q;

  // Next register contents: only the addressed entry changes on a write.
  always_comb begin
    for (int i = 0; i < NUM_REGS; i++) regs_d[i] = regs_q[i];
    if (wr_en) regs_d[bus.write_address] = bus.write_data;
  end

  // Register array storage, cleared immediately by rst.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      for (int i = 0; i < NUM_REGS; i++) regs_q[i] <= '0;
    end else begin
      for (int i = 0; i < NUM_REGS; i++) regs_q[i] <= regs_d[i];
    end
  end

  // Read ports; with bypass a same-cycle write to the read address is forwarded.
  always_comb begin
    a = regs_q[bus.address_a];
    b = regs_q[bus.address_b];
`ifdef ALU_REGFILE_BYPASS_EN
    if (wr_en && (bus.write_address == bus.address_a)) a = bus.write_data;
    if (wr_en && (bus.write_address == bus.address_b)) b = bus.write_data;
`endif
  end

  // ALU: carry reports add carry-out or sub borrow, zero elsewhere.
  always_comb begin
    sum        = '0;
    result     = a;
    carry_flag = 1'b0;
    unique case (bus.opcode)
      OP_ADD: begin
        sum        = {1'b0, a} + {1'b0, b};
        result     = sum[DATA_WIDTH-1:0];
        carry_flag = sum[DATA_WIDTH];
      end
      OP_SUB: begin
        result     = a - b;
        carry_flag = (a < b);
      end
      OP_AND:  result = a & b;
      OP_OR:   result = a | b;
      OP_XOR:  result = a ^ b;
      OP_NOT:  result = ~a;
      OP_SHL:  result = a << b[3:0];
      OP_SHR:  result = a >> b[3:0];
      default: result = a;
    endcase
  end

  assign bus.data_a     = a;
  assign bus.data_b     = b;
  assign bus.alu_result = result;
  assign bus.zero       = (result == '0);
  assign bus.carry      = carry_flag;
endmodule

// File: tb/tb_alu_regfile.sv
// tb_alu_regfile: table-driven vectors, hand sequences for reset, wrap,
// write/read collision and mid-cycle reset, plus randomized traffic checked
// against an arithmetic reference model.
module tb_alu_regfile;
  logic clk;
  logic rst;

  int errors;
  int checks;
  int model_regs [8];

  alu_regfile_if #(.DATA_WIDTH(16), .NUM_REGS(8)) bus ();

  alu_regfile #(.DATA_WIDTH(16), .NUM_REGS(8)) dut (
    .clk (clk),
    .rst (rst),
    .bus (bus)
  );

  typedef struct {
    logic [2:0]  addr_a;
    logic [2:0]  addr_b;
    logic [3:0]  op;
    logic [15:0] res;
    logic        z;
    logic        c;
  } vec_t;

  vec_t vecs [13];

  // clock / reset block
  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  // Reference ALU written from the operation rules with plain integer math.
  task automatic ref_alu(input int op, input int a, input int b,
                         output int res, output int z, output int c);
    int sh;
    sh = b % 16;
    c  = 0;
    case (op)
      2:  begin res = (a + b) % 65536; c = (a + b > 65535) ? 1 : 0; end
      3:  begin res = (a - b + 65536) % 65536; c = (a < b) ? 1 : 0; end
      4:  res = a & b;
      5:  res = a | b;
      6:  res = a ^ b;
      7:  res = 65535 - a;
      9:  res = (a * (1 << sh)) % 65536;
      10: res = a / (1 << sh);
      default: res = a;
    endcase
    z = (res == 0) ? 1 : 0;
  endtask

  function automatic int model_read(input int addr);
`ifdef ALU_REGFILE_BYPASS_EN
    if (bus.write_enable && !rst && int'(bus.write_address) == addr) return int'(bus.write_data);
`endif
    return model_regs[addr];
  endfunction

  // Compare all outputs for the currently driven inputs against the model.
  task automatic check_model(input string name);
    int a, b, res, z, c;
    a = model_read(int'(bus.address_a));
    b = model_read(int'(bus.address_b));
    ref_alu(int'(bus.opcode), a, b, res, z, c);
    check({name, ".data_a"}, 32'(bus.data_a), 32'(a));
    check({name, ".data_b"}, 32'(bus.data_b), 32'(b));
    check({name, ".result"}, 32'(bus.alu_result), 32'(res));
    check({name, ".zero"},   32'(bus.zero), 32'(z));
    check({name, ".carry"},  32'(bus.carry), 32'(c));
  endtask

  // driver tasks
  task automatic wr(input int addr, input int data);
    @(negedge clk);
    bus.write_enable  = 1'b1;
    bus.write_address = 3'(addr);
    bus.write_data    = 16'(data);
    @(posedge clk);
    #1;
    bus.write_enable = 1'b0;
    model_regs[addr] = data;
  endtask

  task automatic set_rd(input int aa, input int ab, input logic [3:0] op);
    @(negedge clk);
    bus.address_a = 3'(aa);
    bus.address_b = 3'(ab);
    bus.opcode    = op;
    #1;
  endtask

  initial begin
    errors = 0;
    checks = 0;
    for (int i = 0; i < 8; i++) model_regs[i] = 0;
    bus.address_a     = '0;
    bus.address_b     = '0;
    bus.write_address = '0;
    bus.write_enable  = 1'b0;
    bus.write_data    = '0;
    bus.opcode        = 4'b0010;
    rst = 1'b1;

    vecs[0]  = '{3'd1, 3'd2, 4'b0010, 16'd8,      1'b0, 1'b0};
    vecs[1]  = '{3'd1, 3'd2, 4'b0011, 16'd2,      1'b0, 1'b0};
    vecs[2]  = '{3'd1, 3'd2, 4'b0100, 16'd1,      1'b0, 1'b0};
    vecs[3]  = '{3'd1, 3'd2, 4'b0101, 16'd7,      1'b0, 1'b0};
    vecs[4]  = '{3'd1, 3'd2, 4'b0110, 16'd6,      1'b0, 1'b0};
    vecs[5]  = '{3'd1, 3'd2, 4'b0111, 16'hFFFA,   1'b0, 1'b0};
    vecs[6]  = '{3'd1, 3'd2, 4'b1001, 16'd40,     1'b0, 1'b0};
    vecs[7]  = '{3'd1, 3'd2, 4'b1010, 16'd0,      1'b1, 1'b0};
    vecs[8]  = '{3'd1, 3'd2, 4'b0000, 16'd5,      1'b0, 1'b0};
    vecs[9]  = '{3'd1, 3'd2, 4'b1000, 16'd5,      1'b0, 1'b0};
    vecs[10] = '{3'd1, 3'd2, 4'b1111, 16'd5,      1'b0, 1'b0};
    vecs[11] = '{3'd2, 3'd1, 4'b0011, 16'hFFFE,   1'b0, 1'b1};
    vecs[12] = '{3'd0, 3'd1, 4'b0001, 16'd0,      1'b1, 1'b0};

    // Reset state: every register reads 0; add gives zero, not gives FFFF.
    repeat (2) @(posedge clk);
    for (int i = 0; i < 8; i++) begin
      @(negedge clk);
      bus.address_a = 3'(i);
      bus.opcode    = 4'b0010;
      #1;
      check($sformatf("reset.r%0d", i), 32'(bus.data_a), 32'h0);
      check($sformatf("reset.zero%0d", i), 32'(bus.zero), 32'h1);
    end
    bus.opcode = 4'b0111;
    #1;
    check("reset.not_result", 32'(bus.alu_result), 32'hFFFF);
    check("reset.not_zero", 32'(bus.zero), 32'h0);
    @(negedge clk);
    rst = 1'b0;
    @(posedge clk);

    // Table-driven vectors with r1=5, r2=3.
    wr(1, 5);
    wr(2, 3);
    for (int i = 0; i < 13; i++) begin
      set_rd(int'(vecs[i].addr_a), int'(vecs[i].addr_b), vecs[i].op);
      check($sformatf("vec%0d.result", i), 32'(bus.alu_result), 32'(vecs[i].res));
      check($sformatf("vec%0d.zero", i),   32'(bus.zero), 32'(vecs[i].z));
      check($sformatf("vec%0d.carry", i),  32'(bus.carry), 32'(vecs[i].c));
    end

    // Subtract to zero and subtract with borrow.
    wr(1, 7); wr(2, 7);
    set_rd(1, 2, 4'b0011);
    check("sub_eq.result", 32'(bus.alu_result), 32'h0);
    check("sub_eq.zero", 32'(bus.zero), 32'h1);
    check("sub_eq.carry", 32'(bus.carry), 32'h0);
    wr(1, 0); wr(2, 1);
    set_rd(1, 2, 4'b0011);
    check("sub_borrow.result", 32'(bus.alu_result), 32'hFFFF);
    check("sub_borrow.carry", 32'(bus.carry), 32'h1);

    // Add wrap-around and shift out of the top bit.
    wr(1, 16'hFFFF); wr(2, 1);
    set_rd(1, 2, 4'b0010);
    check("add_wrap.result", 32'(bus.alu_result), 32'h0);
    check("add_wrap.zero", 32'(bus.zero), 32'h1);
    check("add_wrap.carry", 32'(bus.carry), 32'h1);
    set_rd(1, 2, 4'b1001);
    check("shl.result", 32'(bus.alu_result), 32'hFFFE);
    check("shl.carry", 32'(bus.carry), 32'h0);

    // Same-cycle write and read of r3 on both read ports.
    wr(3, 16'h1111);
    @(negedge clk);
    bus.address_a     = 3'd3;
    bus.address_b     = 3'd3;
    bus.opcode        = 4'b0000;
    bus.write_enable  = 1'b1;
    bus.write_address = 3'd3;
    bus.write_data    = 16'h00AA;
    #1;
`ifdef ALU_REGFILE_BYPASS_EN
    check("collide.before_a", 32'(bus.data_a), 32'h00AA);
    check("collide.before_b", 32'(bus.data_b), 32'h00AA);
    check("collide.before_alu", 32'(bus.alu_result), 32'h00AA);
`else
    check("collide.before_a", 32'(bus.data_a), 32'h1111);
    check("collide.before_b", 32'(bus.data_b), 32'h1111);
    check("collide.before_alu", 32'(bus.alu_result), 32'h1111);
`endif
    @(posedge clk);
    #1;
    bus.write_enable = 1'b0;
    model_regs[3] = 16'h00AA;
    check("collide.after_a", 32'(bus.data_a), 32'h00AA);
    check("collide.after_b", 32'(bus.data_b), 32'h00AA);

    // Mid-cycle reset with a write pending: clear at once, write dropped.
    wr(4, 16'h1234);
    @(negedge clk);
    bus.address_a     = 3'd4;
    bus.address_b     = 3'd3;
    bus.opcode        = 4'b0010;
    bus.write_enable  = 1'b1;
    bus.write_address = 3'd4;
    bus.write_data    = 16'h5678;
    #2;
    rst = 1'b1;
    for (int i = 0; i < 8; i++) model_regs[i] = 0;
    #1;
    check("midrst.data_a", 32'(bus.data_a), 32'h0);
    check("midrst.data_b", 32'(bus.data_b), 32'h0);
    check("midrst.zero", 32'(bus.zero), 32'h1);
    @(posedge clk);
    #1;
    check("midrst.after_edge", 32'(bus.data_a), 32'h0);
    bus.write_enable = 1'b0;
    @(negedge clk);
    rst = 1'b0;
    @(posedge clk);
    #1;
    check("midrst.released_r4", 32'(bus.data_a), 32'h0);

    // Randomized traffic against the reference model.
    for (int n = 0; n < 300; n++) begin
      @(negedge clk);
      bus.address_a     = 3'($urandom_range(0, 7));
      bus.address_b     = 3'($urandom_range(0, 7));
      bus.write_address = 3'($urandom_range(0, 7));
      bus.write_enable  = 1'($urandom_range(0, 1));
      bus.opcode        = 4'($urandom_range(0, 15));
      case ($urandom_range(0, 3))
        0:       bus.write_data = 16'($urandom_range(0, 15));
        1:       bus.write_data = 16'($urandom_range(16'hFFF0, 16'hFFFF));
        default: bus.write_data = 16'($urandom());
      endcase
      #1;
      check_model($sformatf("rand%0d", n));
      @(posedge clk);
      if (bus.write_enable) model_regs[bus.write_address] = int'(bus.write_data);
      #1;
    end
    bus.write_enable = 1'b0;

    // Final readback of every register through port B.
    for (int i = 0; i < 8; i++) begin
      set_rd(0, i, 4'b0000);
      check($sformatf("final.r%0d", i), 32'(bus.data_b), 32'(model_regs[i]));
    end

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end
endmodule

// File: doc/alu_regfile.md
ALU_REGFILE -- requirements
Module: alu_regfile

Interface
REQ-001 The block SHALL have parameter DATA_WIDTH, default 16, the register, operand and result width.
REQ-002 The block SHALL have parameter NUM_REGS, default 8, the register count; address width is log2(NUM_REGS), 3 at default.
REQ-003 The block SHALL have port clk, input, 1, the single clock; all state updates on its rising edge.
REQ-004 The block SHALL have port rst, input, 1, the asynchronous active-high reset.
REQ-005 The block SHALL have port address_a, input, 3, the read port A register index.
REQ-006 The block SHALL have port address_b, input, 3, the read port B register index.
REQ-007 The block SHALL have port write_address, input, 3, the write port register index.
REQ-008 The block SHALL have port write_enable, input, 1, which when high writes write_data at the next clk rising edge.
REQ-009 The block SHALL have port write_data, input, DATA_WIDTH, the write port data.
REQ-010 The block SHALL have port opcode, input, 4, the ALU operation select.
REQ-011 The block SHALL have port data_a, output, DATA_WIDTH, the register[address_a] value.
REQ-012 The block SHALL have port data_b, output, DATA_WIDTH, the register[address_b] value.
REQ-013 The block SHALL have port alu_result, output, DATA_WIDTH, the ALU result computed from data_a (a) and data_b (b).
REQ-014 The block SHALL have port zero, output, 1, high when alu_result equals 0.
REQ-015 The block SHALL have port carry, output, 1, the carry/borrow from add/sub and 0 for all other opcodes.

Function
REQ-016 Reads SHALL be combinational: data_a/data_b follow address changes and register contents with zero clock latency.
REQ-017 Writes SHALL be synchronous: at clk rising edge with write_enable=1, register[write_address] <= write_data; with write_enable=0 no register SHALL change.
REQ-018 All NUM_REGS registers SHALL be general purpose and writable; there is no hardwired zero register.
REQ-019 Without bypass, a read of the register being written in the same cycle SHALL return the old value until after the edge.
REQ-020 The ALU SHALL be purely combinational (no latency) and SHALL perform the following operations by opcode:
  - 0010 add: a+b, modulo 2^DATA_WIDTH; carry = bit-16 carry-out.
  - 0011 sub: a-b, modulo 2^DATA_WIDTH; carry = 1 when a<b unsigned (borrow).
  - 0100 and: a&b.
  - 0101 or: a|b.
  - 0110 xor: a^b.
  - 0111 not: ~a.
  - 1001 shl: a << b[3:0].
  - 1010 shr logical: a >> b[3:0].
  - All other opcodes (incl. 0000, 0001, 1000, 1100, 1111) pass: result = a.
REQ-021 zero SHALL be (alu_result == 0) for every opcode, including pass.
REQ-022 Overflow on add/sub SHALL wrap silently; no saturation, no exception output.

Reset
REQ-023 When rst is high, all registers SHALL clear to 0 immediately, independent of clk.
REQ-024 While rst is high, writes SHALL be ignored.
REQ-025 Because rst clears all registers, data_a=data_b=0, alu_result=0 for any opcode except not (which gives 16'hFFFF), and zero=1 for any opcode except not.
REQ-026 Release of rst SHALL be synchronized internally so that the first write is taken on the first full clk edge after deassertion.

Configuration
REQ-027 With macro ALU_REGFILE_BYPASS_EN defined, when write_enable=1 and write_address equals address_a (or address_b), data_a (or data_b) SHALL show write_data combinationally in the same cycle, so the ALU also sees it.
REQ-028 Without ALU_REGFILE_BYPASS_EN, reads SHALL follow REQ-019 (old value).

Verification
REQ-029 Assert rst, then check all 8 registers via address_a=0..7 -> data_a=0; with opcode 0010, zero=1.
REQ-030 Write r1=5, r2=3, then set address_a=1, address_b=2 -> opcode 0010 gives 8 (carry 0), 0011 gives 2, 0100 gives 1, 0101 gives 7, 0110 gives 6.
REQ-031 With r1=r2=7, opcode 0011 -> alu_result=0, zero=1, carry=0; with r1=0, r2=1, opcode 0011 -> 16'hFFFF, carry=1.
REQ-032 With r1=16'hFFFF, r2=1, opcode 0010 -> alu_result=0, zero=1, carry=1; opcode 1001 -> 16'hFFFE.
REQ-033 Write r3=16'h00AA with address_a=3 in the same cycle -> data_a=old value before the edge (0xAA only with ALU_REGFILE_BYPASS_EN defined), and 0xAA after the edge in both builds.
REQ-034 Assert rst mid-cycle while write_enable=1 -> registers clear immediately and the pending write is discarded.
